// File: rtl/adder_tree_sched_if.sv
// Bundle of the requester, response and adder-tree signals seen by adder_tree_sched.
// The slave modport is the scheduler's view; master is the environment's view.
interface adder_tree_sched_if #(
  parameter int N_REQ = 2,
  parameter int DW    = 32
);
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_ready;
  logic [N_REQ*4*DW-1:0]     req_data;
  logic [N_REQ-1:0]          rsp_valid;
  logic [N_REQ-1:0]          rsp_ready;
  logic [N_REQ*(DW+2)-1:0]   rsp_data;
  logic                      tree_in_valid;
  logic [4*DW-1:0]           tree_operands;
  logic                      tree_out_valid;
  logic [DW+1:0]             tree_sum;
  logic [N_REQ-1:0]          busy;
  logic                      tag_err;

  modport slave (
    input  req_valid, req_data, rsp_ready, tree_out_valid, tree_sum,
    output req_ready, rsp_valid, rsp_data, tree_in_valid, tree_operands, busy, tag_err
  );

  modport master (
    output req_valid, req_data, rsp_ready, tree_out_valid, tree_sum,
    input  req_ready, rsp_valid, rsp_data, tree_in_valid, tree_operands, busy, tag_err
  );
endinterface

// File: rtl/adder_tree_sched.sv
// Round-robin scheduler sharing one pipelined 4-operand adder tree among N_REQ requesters.
// A tag pipeline matching the tree latency routes each sum back to the requester that issued it.
module adder_tree_sched #(
  parameter int N_REQ   = 2,
  parameter int DW      = 32,
  parameter int LATENCY = 2
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  adder_tree_sched_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = DW + 2;
  localparam int OW = 4 * DW;
  localparam int NS = LATENCY + 1;

  logic [IW-1:0]       r_rr_ptr;
  logic [N_REQ-1:0]    r_busy;
  logic [N_REQ-1:0]    r_rsp_valid;
  logic [N_REQ*SW-1:0] r_rsp_data;
  logic                r_tree_in_valid;
  logic [OW-1:0]       r_tree_operands;
  logic [NS-1:0]       r_tag_valid;
  logic [IW-1:0]       r_tag_idx [NS];
  logic                r_tag_err;

  logic [N_REQ-1:0]    w_elig;
  logic [N_REQ-1:0]    w_req_ready;
  logic [N_REQ-1:0]    w_rsp_fire;
  logic [N_REQ-1:0]    w_capture_onehot;
  logic                w_grant_vld;
  logic [IW-1:0]       w_grant_idx;
  logic [IW-1:0]       w_next_ptr;
  logic                w_tag_out_vld;
  logic [IW-1:0]       w_tag_out_idx;
  logic                w_capture;
  logic                w_mismatch;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int offs);
    int sum_v;
    sum_v = (int'(base) + offs) % N_REQ;
    return IW'(sum_v);
  endfunction

  // Round-robin search starting at the pointer; eligibility uses the registered busy
  always_comb begin
    w_elig      = bus.req_valid & ~r_busy;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_grant_vld && w_elig[wrap_idx(r_rr_ptr, k)]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = wrap_idx(r_rr_ptr, k);
      end else begin
        w_grant_vld = w_grant_vld;
      end
    end
    w_req_ready              = '0;
    w_req_ready[w_grant_idx] = w_grant_vld;
    w_next_ptr               = wrap_idx(w_grant_idx, 1);
  end

  // Tag output qualifies the tree result; any disagreement is a protocol error
  always_comb begin
    w_tag_out_vld                   = r_tag_valid[NS-1];
    w_tag_out_idx                   = r_tag_idx[NS-1];
    w_capture                       = bus.tree_out_valid & w_tag_out_vld;
    w_mismatch                      = bus.tree_out_valid ^ w_tag_out_vld;
    w_rsp_fire                      = r_rsp_valid & bus.rsp_ready;
    w_capture_onehot                = '0;
    w_capture_onehot[w_tag_out_idx] = w_capture;
  end

  // Arbitration pointer, issue register and tag pipeline
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rr_ptr        <= '0;
      r_tree_in_valid <= 1'b0;
      r_tree_operands <= '0;
      r_tag_valid     <= '0;
      for (int s = 0; s < NS; s++) begin
        r_tag_idx[s] <= '0;
      end
    end else begin
      r_tree_in_valid <= w_grant_vld;
      r_tag_valid     <= {r_tag_valid[NS-2:0], w_grant_vld};
      r_tag_idx[0]    <= w_grant_idx;
      for (int s = 1; s < NS; s++) begin
        r_tag_idx[s] <= r_tag_idx[s-1];
      end
      if (w_grant_vld) begin
        r_rr_ptr        <= w_next_ptr;
        r_tree_operands <= bus.req_data[int'(w_grant_idx)*OW +: OW];
      end else begin
        r_rr_ptr        <= r_rr_ptr;
        r_tree_operands <= r_tree_operands;
      end
    end
  end

  // Busy/response state: set on grant/capture, cleared by the response handshake
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_busy      <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_tag_err   <= 1'b0;
    end else begin
      r_busy      <= (r_busy & ~w_rsp_fire) | w_req_ready;
      r_rsp_valid <= (r_rsp_valid & ~w_rsp_fire) | w_capture_onehot;
      r_tag_err   <= r_tag_err | w_mismatch;
      if (w_capture) begin
        r_rsp_data[int'(w_tag_out_idx)*SW +: SW] <= bus.tree_sum;
      end else begin
        r_rsp_data <= r_rsp_data;
      end
    end
  end

  assign bus.req_ready     = w_req_ready;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_data      = r_rsp_data;
  assign bus.tree_in_valid = r_tree_in_valid;
  assign bus.tree_operands = r_tree_operands;
  assign bus.busy          = r_busy;
  assign bus.tag_err       = r_tag_err;
endmodule

// File: tb/tb_adder_tree_sched.sv
// Directed bench for adder_tree_sched with four requesters and a two-stage reference adder tree.
module tb_adder_tree_sched;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SW = DW + 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          spur  = 1'b0;
  logic [1:0]    m_vld = 2'b00;
  logic [SW-1:0] m_s1  = '0;
  logic [SW-1:0] m_s2  = '0;
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 clk = ~clk;

  adder_tree_sched_if #(.N_REQ(N), .DW(DW)) ifc ();

  adder_tree_sched #(.N_REQ(N), .DW(DW), .LATENCY(2)) dut (
    .ACLK    (clk),
    .ARESETN (rst_n),
    .bus     (ifc)
  );

  // Reference tree is never reset, so sums in flight survive a scheduler reset
  always @(posedge clk) begin
    m_vld <= {m_vld[0], ifc.tree_in_valid};
    m_s1  <= SW'(ifc.tree_operands[31:0])  + SW'(ifc.tree_operands[63:32]) +
             SW'(ifc.tree_operands[95:64]) + SW'(ifc.tree_operands[127:96]);
    m_s2  <= m_s1;
  end
  assign ifc.tree_out_valid = m_vld[1] | spur;
  assign ifc.tree_sum       = m_s2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input int a, input int b, input int c, input int d);
    ifc.req_data[i*128 +: 128] = {32'(d), 32'(c), 32'(b), 32'(a)};
  endtask

  function automatic logic [63:0] rsp(input int i);
    return 64'(ifc.rsp_data[i*SW +: SW]);
  endfunction

  task automatic do_reset();
    rst_n         = 1'b0;
    spur          = 1'b0;
    ifc.req_valid = '0;
    ifc.req_data  = '0;
    ifc.rsp_ready = 4'hF;
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int cnt;
    cnt = 0;
    while ((ifc.busy !== 4'h0 || ifc.rsp_valid !== 4'h0) && cnt < 40) begin
      tick();
      cnt++;
    end
    chk(tag, {56'h0, ifc.busy, ifc.rsp_valid}, 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, required finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_req_ready", ifc.req_ready, 64'h0);
    chk("rst_tree_in_valid", ifc.tree_in_valid, 64'h0);
    chk("rst_tree_operands", {63'h0, |ifc.tree_operands}, 64'h0);
    chk("rst_busy", ifc.busy, 64'h0);
    chk("rst_rsp_valid", ifc.rsp_valid, 64'h0);
    chk("rst_rsp_data", {63'h0, |ifc.rsp_data}, 64'h0);
    chk("rst_tag_err", ifc.tag_err, 64'h0);

    // Single job from requester 0: {1,2,3,4} -> 10
    ifc.req_valid = 4'b0001;
    set_ops(0, 1, 2, 3, 4);
    #1;
    chk("t1_ready", ifc.req_ready, 64'h1);
    tick();
    ifc.req_valid = 4'b0000;
    chk("t1_issue", ifc.tree_in_valid, 64'h1);
    chk("t1_op0", 64'(ifc.tree_operands[31:0]), 64'h1);
    chk("t1_op3", 64'(ifc.tree_operands[127:96]), 64'h4);
    chk("t1_busy_set", ifc.busy, 64'h1);
    tick();
    chk("t1_issue_once", ifc.tree_in_valid, 64'h0);
    tick();
    chk("t1_rsp_early", ifc.rsp_valid, 64'h0);
    tick();
    chk("t1_rsp_valid", ifc.rsp_valid, 64'h1);
    chk("t1_rsp_data", rsp(0), 64'd10);
    chk("t1_tag_err", ifc.tag_err, 64'h0);
    tick();
    chk("t1_rsp_released", ifc.rsp_valid, 64'h0);
    chk("t1_busy_clear", ifc.busy, 64'h0);
    chk("t1_data_held", rsp(0), 64'd10);

    // Round-robin fairness: 0 and 1 both requesting continuously
    do_reset();
    set_ops(0, 5, 6, 7, 8);
    set_ops(1, 10, 20, 30, 40);
    ifc.req_valid = 4'b0011;
    #1;
    chk("t2_grant0", ifc.req_ready, 64'h1);
    tick();
    chk("t2_grant1", ifc.req_ready, 64'h2);
    chk("t2_op_r0", 64'(ifc.tree_operands[31:0]), 64'd5);
    tick();
    chk("t2_blocked", ifc.req_ready, 64'h0);
    chk("t2_op_r1", 64'(ifc.tree_operands[31:0]), 64'd10);
    chk("t2_busy_both", ifc.busy, 64'h3);
    tick();
    tick();
    chk("t2_rsp0_valid", ifc.rsp_valid, 64'h1);
    chk("t2_rsp0_data", rsp(0), 64'd26);
    tick();
    chk("t2_rsp1_valid", ifc.rsp_valid, 64'h2);
    chk("t2_rsp1_data", rsp(1), 64'd100);
    chk("t2_regrant0", ifc.req_ready, 64'h1);
    chk("t2_busy_mid", ifc.busy, 64'h2);
    tick();
    chk("t2_regrant1", ifc.req_ready, 64'h2);
    chk("t2_busy_late", ifc.busy, 64'h1);
    ifc.req_valid = 4'b0000;
    wait_idle("t2_drain");

    // Response backpressure on requester 1 with all-ones operands
    set_ops(1, -1, -1, -1, -1);
    ifc.rsp_ready = 4'b1101;
    ifc.req_valid = 4'b0010;
    #1;
    chk("t3_grant1", ifc.req_ready, 64'h2);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_no_regrant", ifc.req_ready, 64'h0);
    end
    chk("t3_rsp_valid", ifc.rsp_valid, 64'h2);
    chk("t3_rsp_data", rsp(1), 64'h3_FFFF_FFFC);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t3_hold_valid", ifc.rsp_valid, 64'h2);
      chk("t3_hold_data", rsp(1), 64'h3_FFFF_FFFC);
      chk("t3_hold_busy", ifc.busy, 64'h2);
      chk("t3_hold_noready", ifc.req_ready, 64'h0);
    end
    ifc.rsp_ready = 4'hF;
    tick();
    chk("t3_released", ifc.rsp_valid, 64'h0);
    chk("t3_busy_clear", ifc.busy, 64'h0);
    chk("t3_eligible_again", ifc.req_ready, 64'h2);
    ifc.req_valid = 4'b0000;
    wait_idle("t3_drain");

    // Back-to-back issue from all four requesters
    do_reset();
    for (int i = 0; i < N; i++) begin
      set_ops(i, i + 1, 2 * (i + 1), 3 * (i + 1), 4 * (i + 1));
    end
    ifc.req_valid = 4'b1111;
    #1;
    chk("t4_grant0", ifc.req_ready, 64'h1);
    tick();
    chk("t4_grant1", ifc.req_ready, 64'h2);
    chk("t4_issue0", {ifc.tree_in_valid, 32'h0, ifc.tree_operands[31:0]}, {1'b1, 32'h0, 32'd1});
    tick();
    chk("t4_grant2", ifc.req_ready, 64'h4);
    chk("t4_issue1", {ifc.tree_in_valid, 32'h0, ifc.tree_operands[31:0]}, {1'b1, 32'h0, 32'd2});
    tick();
    chk("t4_grant3", ifc.req_ready, 64'h8);
    chk("t4_issue2", {ifc.tree_in_valid, 32'h0, ifc.tree_operands[31:0]}, {1'b1, 32'h0, 32'd3});
    tick();
    ifc.req_valid = 4'b0000;
    chk("t4_issue3", {ifc.tree_in_valid, 32'h0, ifc.tree_operands[31:0]}, {1'b1, 32'h0, 32'd4});
    chk("t4_rsp0", {ifc.rsp_valid, rsp(0)[59:0]}, {4'h1, 60'd10});
    tick();
    chk("t4_idle_tree", ifc.tree_in_valid, 64'h0);
    chk("t4_rsp1", {ifc.rsp_valid, rsp(1)[59:0]}, {4'h2, 60'd20});
    tick();
    chk("t4_rsp2", {ifc.rsp_valid, rsp(2)[59:0]}, {4'h4, 60'd30});
    tick();
    chk("t4_rsp3", {ifc.rsp_valid, rsp(3)[59:0]}, {4'h8, 60'd40});
    chk("t4_tag_err", ifc.tag_err, 64'h0);
    wait_idle("t4_drain");

    // Reset while a job is inside the tree
    do_reset();
    set_ops(0, 1, 1, 1, 1);
    ifc.req_valid = 4'b0001;
    #1;
    chk("t5_grant", ifc.req_ready, 64'h1);
    tick();
    ifc.req_valid = 4'b0000;
    chk("t5_issue", ifc.tree_in_valid, 64'h1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_tiv", ifc.tree_in_valid, 64'h0);
    chk("t5_rst_ops", {63'h0, |ifc.tree_operands}, 64'h0);
    chk("t5_rst_busy", ifc.busy, 64'h0);
    chk("t5_rst_rsp", ifc.rsp_valid, 64'h0);
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    chk("t5_tag_err", ifc.tag_err, 64'h1);
    chk("t5_no_rsp", ifc.rsp_valid, 64'h0);
    chk("t5_busy", ifc.busy, 64'h0);

    // Spurious tree result with nothing issued
    do_reset();
    chk("t6_clean", ifc.tag_err, 64'h0);
    spur = 1'b1;
    tick();
    spur = 1'b0;
    chk("t6_tag_err", ifc.tag_err, 64'h1);
    chk("t6_no_rsp", ifc.rsp_valid, 64'h0);
    tick();
    tick();
    chk("t6_sticky", ifc.tag_err, 64'h1);
    chk("t6_still_no_rsp", ifc.rsp_valid, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
